// File: rtl/rt_ctrl_pkg.sv
// ============================================================================
// Module      : rt_ctrl_pkg
// Description : Shared types and opcode constants for the racetrack LiM memory
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_RESP     = 3'd3,
        ST_ERR_RESP = 3'd4
    } ctrl_state_t;

    // Encodings match the core's riscv_defines FUNCT_* values.
    localparam logic [2:0] FUNCT_AND  = 3'b111;
    localparam logic [2:0] FUNCT_OR   = 3'b110;
    localparam logic [2:0] FUNCT_XOR  = 3'b100;
    localparam logic [2:0] FUNCT_NONE = 3'b000;

    function automatic logic is_lim_op(input logic [2:0] op);
        return (op == FUNCT_AND) || (op == FUNCT_OR) || (op == FUNCT_XOR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rt_wordline_decoder.sv
// ============================================================================
// Module      : rt_wordline_decoder
// Description : Expands a byte address and byte enables into the packed
//               one-bit-per-byte word-line vector of the racetrack array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rt_wordline_decoder #(
    parameter int ADDR_WIDTH = 10,
    parameter int BYTES      = 1024
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            be,
    input  logic                  we,
    output logic [BYTES-1:0]      word_lines
);

    logic [3:0]            lanes;
    logic [ADDR_WIDTH-1:0] base;

    // Reads always fetch the whole word; writes touch only enabled lanes.
    assign lanes      = we ? be : 4'hF;
    assign base       = addr & ~ADDR_WIDTH'(3);
    assign word_lines = {{(BYTES-4){1'b0}}, lanes} << base;

endmodule

`default_nettype wire

// File: rtl/rt_lim_mem_ctrl.sv
// ============================================================================
// Module      : rt_lim_mem_ctrl
// Description : Core-side LSU to racetrack LiM memory port controller; one
//               outstanding request, timeout and out-of-range error response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rt_lim_mem_ctrl
    import rt_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTES          = 1024,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_req_i,
    output logic             data_gnt_o,
    input  logic [31:0]      data_addr_i,
    input  logic             data_we_i,
    input  logic [3:0]       data_be_i,
    input  logic [2:0]       data_op_i,
    input  logic [31:0]      data_wdata_i,
    output logic             data_rvalid_o,
    output logic [31:0]      data_rdata_o,
    output logic             data_err_o,
    output logic             rt_en_o,
    output logic             rt_we_o,
    output logic [BYTES-1:0] rt_word_lines_o,
    output logic [2:0]       rt_opcode_o,
    output logic [31:0]      rt_mask_o,
    output logic [31:0]      rt_wdata_o,
    input  logic [31:0]      rt_rdata_i,
    input  logic             rt_rvalid_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_t           state;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [3:0]            req_be;
    logic                  req_we;
    logic [CNT_W-1:0]      tmo_cnt;
    logic                  port_active;
    logic                  lim_in;
    logic                  addr_bad;
    logic [BYTES-1:0]      decoded_lines;

    assign lim_in     = is_lim_op(data_op_i);
    assign addr_bad   = data_addr_i >= 32'(BYTES);
    assign data_gnt_o = (state == ST_IDLE) && data_req_i;

    rt_wordline_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYTES      (BYTES)
    ) u_decoder (
        .addr       (req_addr),
        .be         (req_be),
        .we         (req_we),
        .word_lines (decoded_lines)
    );

    // Word lines are only live while the request owns the RT port.
    assign rt_word_lines_o = port_active ? decoded_lines : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            req_addr      <= '0;
            req_be        <= '0;
            req_we        <= 1'b0;
            tmo_cnt       <= '0;
            port_active   <= 1'b0;
            rt_en_o       <= 1'b0;
            rt_we_o       <= 1'b0;
            rt_opcode_o   <= FUNCT_NONE;
            rt_mask_o     <= '0;
            rt_wdata_o    <= '0;
            data_rvalid_o <= 1'b0;
            data_err_o    <= 1'b0;
            data_rdata_o  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_req_i) begin
                        req_addr <= data_addr_i[ADDR_WIDTH-1:0];
                        req_be   <= data_be_i;
                        req_we   <= data_we_i;
                        if (addr_bad) begin
                            state         <= ST_ERR_RESP;
                            data_rvalid_o <= 1'b1;
                            data_err_o    <= 1'b1;
                            data_rdata_o  <= '0;
                        end else begin
                            state       <= ST_ISSUE;
                            tmo_cnt     <= '0;
                            port_active <= 1'b1;
                            rt_en_o     <= 1'b1;
                            rt_we_o     <= data_we_i;
                            rt_opcode_o <= lim_in ? data_op_i : FUNCT_NONE;
                            rt_mask_o   <= lim_in ? data_wdata_i : '0;
                            rt_wdata_o  <= data_wdata_i;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (rt_rvalid_i) begin
                        state   <= ST_CAPTURE;
                        rt_en_o <= 1'b0;
                    end else if (tmo_cnt == CNT_LAST) begin
                        state         <= ST_ERR_RESP;
                        port_active   <= 1'b0;
                        rt_en_o       <= 1'b0;
                        rt_we_o       <= 1'b0;
                        rt_opcode_o   <= FUNCT_NONE;
                        rt_mask_o     <= '0;
                        rt_wdata_o    <= '0;
                        data_rvalid_o <= 1'b1;
                        data_err_o    <= 1'b1;
                        data_rdata_o  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // RT registers read data on its READ cycle, so it is valid here.
                    state         <= ST_RESP;
                    data_rdata_o  <= req_we ? 32'h0 : rt_rdata_i;
                    data_rvalid_o <= 1'b1;
                    data_err_o    <= 1'b0;
                    port_active   <= 1'b0;
                    rt_we_o       <= 1'b0;
                    rt_opcode_o   <= FUNCT_NONE;
                    rt_mask_o     <= '0;
                    rt_wdata_o    <= '0;
                end
                ST_RESP: begin
                    state         <= ST_IDLE;
                    data_rvalid_o <= 1'b0;
                    data_rdata_o  <= '0;
                end
                ST_ERR_RESP: begin
                    state         <= ST_IDLE;
                    data_rvalid_o <= 1'b0;
                    data_err_o    <= 1'b0;
                    data_rdata_o  <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rt_lim_mem_ctrl.sv
// ============================================================================
// Module      : tb_rt_lim_mem_ctrl
// Description : Scoreboard bench pairing rt_lim_mem_ctrl with a small
//               behavioural racetrack memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rt_lim_mem_ctrl;
    import rt_ctrl_pkg::*;

    localparam int ADDR_WIDTH     = 10;
    localparam int BYTES          = 1024;
    localparam int TIMEOUT_CYCLES = 32;
    localparam int LIM_WAIT       = 2;
    localparam logic [2:0] OP_SW  = 3'b010;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rt_rst = 1'b1;
    logic             data_req = 1'b0;
    logic             data_gnt;
    logic [31:0]      data_addr = '0;
    logic             data_we = 1'b0;
    logic [3:0]       data_be = '0;
    logic [2:0]       data_op = '0;
    logic [31:0]      data_wdata = '0;
    logic             data_rvalid;
    logic [31:0]      data_rdata;
    logic             data_err;
    logic             rt_en;
    logic             rt_we;
    logic [BYTES-1:0] rt_wl;
    logic [2:0]       rt_opcode;
    logic [31:0]      rt_mask;
    logic [31:0]      rt_wdata;
    logic [31:0]      rt_rdata = '0;
    logic             rt_rvalid;

    int total = 0;
    int bad   = 0;
    int rsp_idx = 0;
    logic [32:0] exp_q[$];

    logic [BYTES-1:0] last_wl = '0;
    logic [2:0]       last_op = '0;
    logic [31:0]      last_mask = '0;
    logic             en_seen = 1'b0;

    always #5 clk = ~clk;

    rt_lim_mem_ctrl #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .BYTES          (BYTES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .data_req_i      (data_req),
        .data_gnt_o      (data_gnt),
        .data_addr_i     (data_addr),
        .data_we_i       (data_we),
        .data_be_i       (data_be),
        .data_op_i       (data_op),
        .data_wdata_i    (data_wdata),
        .data_rvalid_o   (data_rvalid),
        .data_rdata_o    (data_rdata),
        .data_err_o      (data_err),
        .rt_en_o         (rt_en),
        .rt_we_o         (rt_we),
        .rt_word_lines_o (rt_wl),
        .rt_opcode_o     (rt_opcode),
        .rt_mask_o       (rt_mask),
        .rt_wdata_o      (rt_wdata),
        .rt_rdata_i      (rt_rdata),
        .rt_rvalid_i     (rt_rvalid)
    );

    // Racetrack model: IDLE -> PORT_SET -> [LIM_WAIT] -> READ/WRITE -> PORT_RESET.
    typedef enum logic [2:0] {RT_IDLE, RT_SET, RT_LIM, RT_RD, RT_WR, RT_PRST} rt_state_t;
    rt_state_t rt_st = RT_IDLE;
    int        lim_cnt = 0;
    logic [7:0] mem [0:BYTES-1];

    function automatic logic [31:0] rd_word(input logic [BYTES-1:0] wl);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < BYTES; i++)
            if (wl[i]) w[(i % 4) * 8 +: 8] = mem[i];
        return w;
    endfunction

    function automatic logic [31:0] lim_fn(input logic [2:0] op, input logic [31:0] w,
                                           input logic [31:0] m);
        case (op)
            FUNCT_AND: return w & m;
            FUNCT_OR:  return w | m;
            FUNCT_XOR: return w ^ m;
            default:   return w;
        endcase
    endfunction

    function automatic logic [7:0] wr_byte(input logic [2:0] op, input logic [31:0] wd,
                                           input logic [31:0] m, input logic [31:0] old,
                                           input int lane);
        logic [31:0] r;
        r = (op == FUNCT_NONE) ? wd : lim_fn(op, old, m);
        return r[lane * 8 +: 8];
    endfunction

    assign rt_rvalid = (rt_st == RT_RD) || (rt_st == RT_WR);

    always @(posedge clk or posedge rt_rst) begin
        if (rt_rst) begin
            rt_st   <= RT_IDLE;
            lim_cnt <= 0;
        end else begin
            case (rt_st)
                RT_IDLE: if (rt_en) rt_st <= RT_SET;
                RT_SET: begin
                    if (rt_opcode == FUNCT_AND || rt_opcode == FUNCT_OR) begin
                        rt_st   <= RT_LIM;
                        lim_cnt <= 0;
                    end else begin
                        rt_st <= rt_we ? RT_WR : RT_RD;
                    end
                end
                RT_LIM: begin
                    if (lim_cnt == LIM_WAIT - 1) rt_st <= rt_we ? RT_WR : RT_RD;
                    else lim_cnt <= lim_cnt + 1;
                end
                RT_RD: begin
                    rt_rdata <= lim_fn(rt_opcode, rd_word(rt_wl), rt_mask);
                    rt_st    <= RT_PRST;
                end
                RT_WR: begin
                    for (int i = 0; i < BYTES; i++)
                        if (rt_wl[i])
                            mem[i] <= wr_byte(rt_opcode, rt_wdata, rt_mask, rd_word(rt_wl), i % 4);
                    rt_st <= RT_PRST;
                end
                default: if (!rt_en) rt_st <= RT_IDLE;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every rvalid, snapshots the RT port.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rt_en) begin
                last_wl   = rt_wl;
                last_op   = rt_opcode;
                last_mask = rt_mask;
                en_seen   = 1'b1;
            end
            if (data_rvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", 64'(data_rvalid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rdata#%0d", rsp_idx), 64'(data_rdata), 64'(e[31:0]));
                    check($sformatf("err#%0d", rsp_idx), 64'(data_err), 64'(e[32]));
                    rsp_idx++;
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [2:0] o, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee, input int el);
        int n;
        int lat;
        bit got;
        exp_q.push_back({ee, er});
        @(negedge clk);
        data_addr = a; data_we = w; data_be = b; data_op = o; data_wdata = wd;
        data_req = 1'b1;
        n = 0;
        #1;
        while (!data_gnt && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!data_gnt) begin
            check("gnt_timeout", 64'(data_gnt), 64'd1);
            data_req = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        @(posedge clk); #1;
        data_req = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (data_rvalid) got = 1'b1;
        end
        if (!got) check("rvalid_timeout", 64'(got), 64'd1);
        else      check($sformatf("latency@%0h", a), 64'(lat), 64'(el));
    endtask

    function automatic logic [BYTES-1:0] wl_exp(input int base, input logic [3:0] lanes);
        logic [BYTES-1:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[base + k] = lanes[k];
        return v;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_gnt",    64'(data_gnt),    64'd0);
        check("rst_rvalid", 64'(data_rvalid), 64'd0);
        check("rst_en",     64'(rt_en),       64'd0);
        check("rst_wl_zero", 64'(rt_wl == '0), 64'd1);
        rst = 1'b0;
        rt_rst = 1'b0;

        // Plain store then load
        do_req(32'h10, 1'b1, 4'hF, OP_SW, 32'hA5A5_1234, 32'h0, 1'b0, 5);
        check("wl_store_10", 64'(last_wl == wl_exp(16, 4'hF)), 64'd1);
        do_req(32'h10, 1'b0, 4'hF, OP_SW, 32'h0, 32'hA5A5_1234, 1'b0, 5);
        check("wl_load_10", 64'(last_wl == wl_exp(16, 4'hF)), 64'd1);
        check("op_plain", 64'(last_op), 64'(FUNCT_NONE));

        // Single-lane store merge
        do_req(32'h20, 1'b1, 4'hF, OP_SW, 32'h1111_1111, 32'h0, 1'b0, 5);
        do_req(32'h20, 1'b1, 4'b0100, OP_SW, 32'h00AB_0000, 32'h0, 1'b0, 5);
        check("wl_lane_22", 64'(last_wl == wl_exp(32, 4'b0100)), 64'd1);
        do_req(32'h20, 1'b0, 4'hF, OP_SW, 32'h0, 32'h11AB_1111, 1'b0, 5);

        // LiM AND read leaves memory untouched
        do_req(32'h30, 1'b1, 4'hF, OP_SW, 32'hFFFF_00FF, 32'h0, 1'b0, 5);
        do_req(32'h30, 1'b0, 4'hF, FUNCT_AND, 32'h0F0F_0F0F, 32'h0F0F_000F, 1'b0, 5 + LIM_WAIT);
        check("op_and",   64'(last_op),   64'(FUNCT_AND));
        check("mask_and", 64'(last_mask), 64'h0F0F_0F0F);
        do_req(32'h30, 1'b0, 4'hF, OP_SW, 32'h0, 32'hFFFF_00FF, 1'b0, 5);

        // LiM OR write-back
        do_req(32'h40, 1'b1, 4'hF, OP_SW, 32'h0, 32'h0, 1'b0, 5);
        do_req(32'h40, 1'b1, 4'hF, FUNCT_OR, 32'h8000_0001, 32'h0, 1'b0, 5 + LIM_WAIT);
        do_req(32'h40, 1'b0, 4'hF, OP_SW, 32'h0, 32'h8000_0001, 1'b0, 5);

        // Highest legal word, then first illegal address
        do_req(32'h3FC, 1'b1, 4'hF, OP_SW, 32'hDEAD_BEEF, 32'h0, 1'b0, 5);
        check("wl_top", 64'(last_wl == wl_exp(1020, 4'hF)), 64'd1);
        do_req(32'h3FC, 1'b0, 4'hF, OP_SW, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);
        en_seen = 1'b0;
        do_req(32'h400, 1'b0, 4'hF, OP_SW, 32'h0, 32'h0, 1'b1, 1);
        check("oob_no_en", 64'(en_seen), 64'd0);

        // RT stuck in reset: timeout error
        rt_rst = 1'b1;
        do_req(32'h10, 1'b0, 4'hF, OP_SW, 32'h0, 32'h0, 1'b1, TIMEOUT_CYCLES + 1);
        check("tmo_en_low", 64'(rt_en), 64'd0);
        rt_rst = 1'b0;

        // Controller reset mid-ISSUE: no response, back to IDLE
        @(negedge clk);
        data_addr = 32'h10; data_we = 1'b0; data_be = 4'hF; data_op = OP_SW;
        data_req = 1'b1;
        @(posedge clk); #1;
        data_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_en",  64'(rt_en), 64'd0);
        check("midrst_wl",  64'(rt_wl == '0), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        do_req(32'h10, 1'b0, 4'hF, OP_SW, 32'h0, 32'hA5A5_1234, 1'b0, 5);

        repeat (3) @(negedge clk);
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
